card_sprite_reader: RTL and testbench
=====================================

// Module: card_sprite_reader
// PURPOSE
// Read side of the 512x3 card sprite RAM in the 256x240 VGA path. Takes the
// raster pixel stream, tests each pixel against one card box placed at
// (card_x, card_y), and drives rAddr/RE to the RAM. Returns the card colour,
// after the transparency test, to the pixel mixer at a fixed latency.
// PARAMETERS
// CARD_W       16      card width in pixels (CARD_W*CARD_H == 2**ADDR_W)
// CARD_H       32      card height in pixels
// ADDR_W       9       sprite RAM address width
// PIX_W        3       colour width
// COORD_W      8       raster coordinate width (0..255 x, 0..239 y)
// TRANSPARENT  3'b000  colour code treated as see-through
// PORTS
// clock          in   1        system clock, all logic on posedge
// reset_n        in   1        asynchronous, active-low reset
// frame_start    in   1        1-cycle pulse at raster (0,0); latches placement
// card_en        in   1        card is drawn this frame (sampled at frame_start)
// card_x         in   COORD_W  card left edge (sampled at frame_start)
// card_y         in   COORD_W  card top edge (sampled at frame_start)
// pix_valid      in   1        hcount/vcount valid this cycle
// hcount         in   COORD_W  raster x
// vcount         in   COORD_W  raster y
// rAddr          out  ADDR_W   sprite RAM read address
// RE             out  1        sprite RAM read enable
// ram_data       in   PIX_W    sprite RAM dataOut (registered, 1-cycle latency)
// pix_out_valid  out  1        result for pixel issued 3 cycles earlier
// pix_hit        out  1        opaque card pixel at this position
// pix_color      out  PIX_W    card colour when pix_hit, else 0
// hit_count      out  10       opaque hits so far this frame, saturating at 1023
// BEHAVIOUR
// - Reset: every output is 0. FSM goes to IDLE. All pipeline valid/hit bits
//   are cleared. Latched x/y are 0. Reset mid-frame discards in-flight pixels.
// - FSM: IDLE -> ACTIVE on frame_start & card_en. ACTIVE -> IDLE on
//   frame_start & !card_en. ACTIVE -> ACTIVE on frame_start & card_en (re-latch).
// - Latched placement applies from the cycle after frame_start. A pixel in
//   the same cycle as frame_start uses the previous state and placement.
// - hit0 = ACTIVE & pix_valid & hcount>=x0 & hcount<x0+CARD_W &
//   vcount>=y0 & vcount<y0+CARD_H. Compare in COORD_W+1 bits so that boxes
//   running off the right or bottom edge clip and never wrap.
// - addr = (vcount-y0)*CARD_W + (hcount-x0), truncated to ADDR_W (in range by
//   construction).
// - Edge 1: rAddr<=addr, RE<=hit0, v1<=pix_valid, h1<=hit0.
//   rAddr holds its last value when !hit0.
// - Edge 2: RAM presents ram_data; v2<=v1, h2<=h1.
// - Edge 3: pix_out_valid<=v2. pix_hit<=h2 & (ram_data!=TRANSPARENT).
//   pix_color<=that ? ram_data : 0.
// - Latency: exactly 3 clocks from pix_valid to pix_out_valid. Fully
//   pipelined, one pixel per clock, no stall or backpressure.
// - In IDLE, pixels still flow: pix_out_valid follows pix_valid, with
//   pix_hit=0 and RE=0.
// - hit_count: cleared on the cycle after frame_start. Otherwise it
//   increments when edge-3 pix_hit is written 1, and saturates at 1023.
//   frame_start plus a coincident hit: the clear wins.
// - The RAM write port is not driven by this block.
// STRUCTURE
// - card_pkg holds CARD_W, CARD_H, TRANSPARENT, and
//   typedef enum logic {IDLE, ACTIVE} card_rd_state_t.
// - Sub-module card_box_hit: combinational box test plus address calc, reused
//   by later multi-card layers.
// - The rest (FSM, 3-stage pipe, counter) stays in this module.
// TESTING
// - Reset: reset_n=0 mid-stream -> all outputs 0 immediately; first
//   pix_out_valid comes 3 cycles after the first pix_valid after release.
// - Placement (40,100), card_en=1, pixel (40,100) -> rAddr=0, RE=1 on
//   edge 1. Pixel (55,131) -> rAddr=511. RAM data 3'b101 -> pix_hit=1,
//   pix_color=5 at edge 3.
// - Pixel (39,100) and pixel (56,100) -> RE=0, pix_hit=0, pix_out_valid=1.
// - Placement (250,230): pixel (255,239) -> hit, rAddr=9*16+5=149.
//   Pixel (2,239) -> no hit (no wrap).
// - Transparency: RAM returns 3'b000 on an in-box pixel -> pix_hit=0,
//   pix_color=0, hit_count unchanged.
// - Frame control: frame_start & !card_en -> IDLE, no RE for the whole frame.
//   frame_start coincident with a hit -> hit_count=0 next cycle. Then
//   1100 opaque hits -> hit_count=1023.

Source files
------------

// File: rtl/card_pkg.sv
// card_pkg: shared card geometry, transparency code and reader FSM state type
package card_pkg;
  localparam int CARD_W = 16;
  localparam int CARD_H = 32;
  localparam int ADDR_W = 9;
  localparam int PIX_W = 3;
  localparam int COORD_W = 8;
  localparam logic [PIX_W-1:0] TRANSPARENT = 3'b000;
  typedef enum logic {IDLE, ACTIVE} card_rd_state_t;
endpackage

// File: rtl/card_box_hit.sv
// card_box_hit: combinational card box test and sprite address (en qualifies hit; hcount/vcount raster, x0/y0 box origin; hit, addr out)
module card_box_hit
  import card_pkg::*;
#(
  parameter int BOX_W = CARD_W,
  parameter int BOX_H = CARD_H,
  parameter int AW = ADDR_W,
  parameter int CW = COORD_W
) (
  input  logic          en,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  output logic          hit,
  output logic [AW-1:0] addr
);
  logic [CW:0] he, ve, xe, ye;
  logic [CW-1:0] dx, dy;
  always_comb begin
    he = {1'b0, hcount};
    ve = {1'b0, vcount};
    xe = {1'b0, x0};
    ye = {1'b0, y0};
    dx = hcount - x0;
    dy = vcount - y0;
    // one extra bit so boxes past the right/bottom edge clip instead of wrapping
    hit = en && he >= xe && he < xe + (CW+1)'(BOX_W) && ve >= ye && ve < ye + (CW+1)'(BOX_H);
    addr = AW'(dy) * AW'(BOX_W) + AW'(dx);
  end
endmodule

// File: rtl/card_sprite_reader.sv
// card_sprite_reader: raster-driven sprite RAM reader with transparency test (clock/reset_n; frame_start/card_* placement; pix_valid/hcount/vcount in; rAddr/RE/ram_data to RAM; pix_out_valid/pix_hit/pix_color/hit_count out, 3-cycle latency)
module card_sprite_reader
  import card_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               card_en,
  input  logic [COORD_W-1:0] card_x,
  input  logic [COORD_W-1:0] card_y,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  output logic [ADDR_W-1:0]  rAddr,
  output logic               RE,
  input  logic [PIX_W-1:0]   ram_data,
  output logic               pix_out_valid,
  output logic               pix_hit,
  output logic [PIX_W-1:0]   pix_color,
  output logic [9:0]         hit_count
);
  card_rd_state_t state;
  logic [COORD_W-1:0] x0, y0;
  logic hit0, v1, h1, v2, h2, hit3;
  logic [ADDR_W-1:0] addr;
  card_box_hit u_box (
    .en    (state == ACTIVE && pix_valid),
    .hcount(hcount),
    .vcount(vcount),
    .x0    (x0),
    .y0    (y0),
    .hit   (hit0),
    .addr  (addr)
  );
  assign hit3 = h2 && ram_data != TRANSPARENT;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      x0 <= '0;
      y0 <= '0;
    end else if (frame_start) begin
      state <= card_en ? ACTIVE : IDLE;
      x0 <= card_x;
      y0 <= card_y;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rAddr <= '0;
      RE <= 1'b0;
      v1 <= 1'b0;
      h1 <= 1'b0;
      v2 <= 1'b0;
      h2 <= 1'b0;
      pix_out_valid <= 1'b0;
      pix_hit <= 1'b0;
      pix_color <= '0;
      hit_count <= '0;
    end else begin
      if (hit0) rAddr <= addr;
      RE <= hit0;
      v1 <= pix_valid;
      h1 <= hit0;
      v2 <= v1;
      h2 <= h1;
      pix_out_valid <= v2;
      pix_hit <= hit3;
      pix_color <= hit3 ? ram_data : '0;
      hit_count <= frame_start ? '0 : (hit3 && hit_count != 10'h3ff) ? hit_count + 10'd1 : hit_count;
    end
endmodule

// File: tb/tb_card_sprite_reader.sv
// tb_card_sprite_reader: directed scoreboard bench for card_sprite_reader
module tb_card_sprite_reader;
  logic clock = 1'b0;
  logic reset_n;
  logic frame_start, card_en, pix_valid, RE, pix_out_valid, pix_hit;
  logic [7:0] card_x, card_y, hcount, vcount;
  logic [8:0] rAddr;
  logic [2:0] ram_data, pix_color;
  logic [9:0] hit_count;
  typedef struct {bit v; bit h; int c;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_act, m_x, m_y, m_ra, m_cnt, p_hit, p_addr, p_fs;
  always #5 clock = ~clock;
  always @(posedge clock) if (RE) ram_data <= 3'(rAddr + 9'd5);
  card_sprite_reader dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .card_en(card_en),
    .card_x(card_x), .card_y(card_y), .pix_valid(pix_valid), .hcount(hcount), .vcount(vcount),
    .rAddr(rAddr), .RE(RE), .ram_data(ram_data), .pix_out_valid(pix_out_valid),
    .pix_hit(pix_hit), .pix_color(pix_color), .hit_count(hit_count)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    q.delete();
    m_act = 0; m_x = 0; m_y = 0; m_ra = 0; m_cnt = 0; p_hit = 0; p_addr = 0; p_fs = 0;
  endtask
  task automatic step(input bit pv, input int h, input int v, input bit fs, input bit en, input int cx, input int cy);
    exp_t e;
    int hit, addr, col, eh, h3;
    @(negedge clock);
    h3 = 0;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("out_valid", pix_out_valid, e.v);
      chk("pix_hit", pix_hit, e.h);
      chk("pix_color", pix_color, e.c);
      h3 = e.h;
    end else chk("out_valid_idle", pix_out_valid, 0);
    if (p_fs) m_cnt = 0;
    else if (h3 && m_cnt < 1023) m_cnt++;
    chk("re", RE, p_hit);
    if (p_hit) m_ra = p_addr;
    chk("raddr", rAddr, m_ra);
    chk("hit_count", hit_count, m_cnt);
    hit = (m_act && pv && h >= m_x && h < m_x + 16 && v >= m_y && v < m_y + 32) ? 1 : 0;
    addr = ((v - m_y) * 16 + (h - m_x)) & 511;
    col = (addr + 5) & 7;
    eh = (hit && col != 0) ? 1 : 0;
    q.push_back('{pv, eh != 0, eh ? col : 0});
    p_hit = hit; p_addr = addr; p_fs = fs;
    if (fs) begin m_act = en; m_x = cx; m_y = cy; end
    pix_valid = pv; hcount = 8'(h); vcount = 8'(v);
    frame_start = fs; card_en = en; card_x = 8'(cx); card_y = 8'(cy);
  endtask
  task automatic pix(input int h, input int v); step(1, h, v, 0, 0, 0, 0); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic frame(input bit en, input int x, input int y); step(0, 0, 0, 1, en, x, y); endtask
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    pix_valid = 0; hcount = 0; vcount = 0; frame_start = 0; card_en = 0; card_x = 0; card_y = 0;
    #1;
    chk("rst_raddr", rAddr, 0);
    chk("rst_re", RE, 0);
    chk("rst_valid", pix_out_valid, 0);
    chk("rst_hit", pix_hit, 0);
    chk("rst_color", pix_color, 0);
    chk("rst_count", hit_count, 0);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    pix_valid = 0; hcount = 0; vcount = 0; frame_start = 0; card_en = 0; card_x = 0; card_y = 0;
    model_clear();
    do_reset();
    frame(1, 40, 100);
    pix(40, 100);
    @(posedge clock); #1;
    chk("corner_raddr", rAddr, 0);
    chk("corner_re", RE, 1);
    pix(55, 131);
    @(posedge clock); #1;
    chk("far_raddr", rAddr, 511);
    idle(1);
    @(posedge clock); #1;
    chk("corner_hit", pix_hit, 1);
    chk("corner_color", pix_color, 5);
    pix(39, 100);
    pix(56, 100);
    pix(47, 115);
    idle(3);
    pix(43, 100);
    idle(3);
    chk("transp_count", hit_count, 3);
    frame(1, 250, 230);
    pix(255, 239);
    @(posedge clock); #1;
    chk("clip_raddr", rAddr, 149);
    chk("clip_re", RE, 1);
    pix(2, 239);
    @(posedge clock); #1;
    chk("nowrap_re", RE, 0);
    pix(250, 230);
    pix(251, 231);
    do_reset();
    pix(10, 10);
    pix(250, 230);
    idle(4);
    frame(1, 40, 100);
    pix(41, 101);
    frame(0, 40, 100);
    for (int i = 0; i < 20; i++) begin
      pix(40 + i % 16, 100 + i);
      chk("off_re", RE, 0);
    end
    idle(3);
    frame(1, 40, 100);
    pix(40, 100);
    idle(1);
    frame(1, 40, 100);
    @(posedge clock); #1;
    chk("clear_wins", hit_count, 0);
    for (int i = 0; i < 1100; i++) pix(40, 100 + i % 32);
    idle(4);
    chk("saturate", hit_count, 1023);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
